truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper_pkg.sv | 17 +
 rtl/truth_table_sweeper_if.sv | 29 ++
 rtl/sync2_ff.sv | 23 ++
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Truth table sweeper shared types.
// States, code type and settle limits.
package truth_table_sweeper_pkg;

  typedef logic [1:0] state_t;
  typedef logic [2:0] code_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_APPLY  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  localparam int unsigned SETTLE_DEF = 4;
  localparam int unsigned SETTLE_MIN = 2;
  localparam int unsigned SETTLE_MAX = 255;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweeper control / gate bus.
// master = controller side, slave = sweeper.
interface truth_table_sweeper_if;
  import truth_table_sweeper_pkg::*;

  logic       start;
  logic       abort;
  logic [7:0] rule;
  code_t      gate_in;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] observed;
  logic [7:0] mismatch;

  modport master (
    output start, abort, rule, gate_out,
    input  gate_in, busy, done, pass,
    input  observed, mismatch
  );

  modport slave (
    input  start, abort, rule, gate_out,
    output gate_in, busy, done, pass,
    output observed, mismatch
  );

endinterface

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for the
// asynchronous gate output.
module sync2_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // shift d through two flops, clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all codes
// and compares the measured table to a rule.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  if (SETTLE_CYCLES < SETTLE_MIN ||
      SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 2..255");
  end

  localparam logic [7:0] SETTLE_LD =
    SETTLE_CYCLES[7:0];

  state_t     state_q, state_d;
  code_t      code_q, code_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rule_q, rule_d;
  logic [7:0] obs_q, obs_d;
  logic [7:0] mis_q, mis_d;
  logic       pass_q, pass_d;
  logic [7:0] obs_next;
  logic       sync_q;

  logic is_idle, is_apply;
  logic is_sample, is_finish;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_apply  = (state_q == ST_APPLY);
  assign is_sample = (state_q == ST_SAMPLE);
  assign is_finish = (state_q == ST_FINISH);

  sync2_ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.gate_out),
    .q    (sync_q)
  );

  // sweep sequencing and result update
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    rule_d   = rule_q;
    obs_d    = obs_q;
    pass_d   = pass_q;
    mis_d    = mis_q;
    obs_next = obs_q;
    obs_next[3'd7 - code_q] = sync_q;
    unique case (1'b1)
      is_idle: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_APPLY;
          rule_d  = bus.rule;
          obs_d   = 8'h00;
          pass_d  = 1'b0;
          mis_d   = 8'h00;
          code_d  = 3'd0;
          cnt_d   = SETTLE_LD;
        end
      end
      is_apply: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          code_d  = 3'd0;
          cnt_d   = 8'd0;
          obs_d   = 8'h00;
          pass_d  = 1'b0;
          mis_d   = 8'h00;
        end else if (cnt_q == 8'd1) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      is_sample: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          code_d  = 3'd0;
          cnt_d   = 8'd0;
          obs_d   = 8'h00;
          pass_d  = 1'b0;
          mis_d   = 8'h00;
        end else begin
          obs_d  = obs_next;
          code_d = code_q + 3'd1;
          if (code_q == 3'd7) begin
            state_d = ST_FINISH;
            cnt_d   = 8'd0;
            pass_d  = (obs_next == rule_q);
            mis_d   = obs_next ^ rule_q;
          end else begin
            state_d = ST_APPLY;
            cnt_d   = SETTLE_LD;
          end
        end
      end
      is_finish: begin
        state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 3'd0;
      cnt_q   <= 8'd0;
      rule_q  <= 8'h00;
      obs_q   <= 8'h00;
      pass_q  <= 1'b0;
      mis_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      rule_q  <= rule_d;
      obs_q   <= obs_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.gate_in  = code_q;
  assign bus.busy     = !is_idle;
  assign bus.done     = is_finish;
  assign bus.pass     = pass_q;
  assign bus.observed = obs_q;
  assign bus.mismatch = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for the sweeper
// against a table-level gate model.
module tb_truth_table_sweeper;

  localparam int S      = 4;
  localparam int DONE_N = 1 + 8 * (S + 1);

  logic       clk;
  logic       rst_n;
  logic [7:0] gtab;
  int         n_chk;
  int         n_bad;

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.gate_out = gtab[3'd7 - bus.gate_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h",
               tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_gin"}, 32'(bus.gate_in), 0);
    chk({tag, "_obs"}, 32'(bus.observed), 0);
    chk({tag, "_mis"}, 32'(bus.mismatch), 0);
  endtask

  // one full sweep; expected table is the
  // gate table, judged against rule r
  task automatic run_sweep(
    input logic [7:0] g,
    input logic [7:0] r,
    input bit         perturb
  );
    int n;
    int pn;
    gtab = g;
    pn = perturb ? int'($urandom_range(3, 35)) : -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.rule  = r;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    chk("busy_on", 32'(bus.busy), 1);
    while (!bus.done && n < 100) begin
      chk("code", 32'(bus.gate_in), (n - 1) / (S + 1));
      bus.start = (n == pn);
      if (n == pn) bus.rule = ~r;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("done_cyc", n, DONE_N);
    chk("busy_fin", 32'(bus.busy), 1);
    chk("observed", 32'(bus.observed), 32'(g));
    chk("pass", 32'(bus.pass), 32'(g == r));
    chk("mismatch", 32'(bus.mismatch), 32'(g ^ r));
    @(negedge clk);
    chk("done_1cyc", 32'(bus.done), 0);
    chk("busy_off", 32'(bus.busy), 0);
    chk("gin_idle", 32'(bus.gate_in), 0);
    chk("obs_hold", 32'(bus.observed), 32'(g));
    chk("pass_hold", 32'(bus.pass), 32'(g == r));
  endtask

  initial begin
    int n;
    int dn;
    logic [7:0] g;
    logic [7:0] r;
    n_chk     = 0;
    n_bad     = 0;
    gtab      = 8'h00;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rule  = 8'h00;
    rst_n     = 1'b0;
    #1;
    chk_reset_vals("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    run_sweep(8'h78, 8'h78, 1'b0);
    run_sweep(8'h78, 8'h96, 1'b0);
    run_sweep(8'h00, 8'h00, 1'b0);
    run_sweep(8'h00, 8'hFF, 1'b0);
    run_sweep(8'h78, 8'h78, 1'b1);

    // abort in IDLE leaves held results alone
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_pass", 32'(bus.pass), 1);
    chk("idle_abort_obs", 32'(bus.observed), 32'h78);

    // start and abort together: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("st_ab_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("st_ab_busy2", 32'(bus.busy), 0);

    // abort while gate_in = 011
    gtab = 8'hFF;
    bus.rule = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.gate_in != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_011", 32'(bus.gate_in), 3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_gin", 32'(bus.gate_in), 0);
    chk("ab_obs", 32'(bus.observed), 0);
    chk("ab_pass", 32'(bus.pass), 0);
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("ab_no_done", dn, 0);

    // reset pulse in APPLY of code 3
    gtab = 8'hFF;
    bus.rule = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 18; i++) @(negedge clk);
    chk("pre_rst_obs", 32'(bus.observed), 32'hE0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_rst");
    run_sweep(8'hA5, 8'hA5, 1'b0);

    // random tables and rules
    for (int i = 0; i < 16; i++) begin
      g = 8'($urandom);
      r = ($urandom_range(0, 2) == 0) ? g : 8'($urandom);
      run_sweep(g, r, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
